uart_paddle_decoder: RTL and testbench
======================================

// Module: uart_paddle_decoder
// PURPOSE
//  Turns UART receiver bytes into clean paddle commands for the pong game.
//  Sits between uart_rx/uart_tx (baud domain) and pong_graph/FSM (clk domain).
//  - Recognises W/S (player 1) and P/L (player 2), case-insensitive.
//  - Drives per-player up/down levels held for a fixed time per keystroke.
//  - Echoes printable bytes back through uart_tx using a start/busy handshake.
// PARAMETERS
//  HOLD_CYCLES  5_000_000  clk cycles a paddle output stays high per keystroke (50 ms @100 MHz); >=2
//  ECHO_EN      1          1 = echo printable bytes to uart_tx; 0 = tx_start tied low
//  CNT_W        23         width of hold counters; must hold HOLD_CYCLES-1
// PORTS
//  clk        in   1  100 MHz system clock
//  reset      in   1  asynchronous, active-high reset
//  rx_data    in   8  byte from uart_rx; stable while rx_done high
//  rx_done    in   1  uart_rx byte-complete flag, baud domain, high >= 4 clk
//  tx_busy    in   1  uart_tx busy flag, baud domain
//  tx_data    out  8  byte to echo
//  tx_start   out  1  echo request to uart_tx (level, held until busy seen)
//  up1        out  1  player-1 paddle up
//  down1      out  1  player-1 paddle down
//  up2        out  1  player-2 paddle up
//  down2      out  1  player-2 paddle down
//  key_pulse  out  1  one-clk pulse per recognised key (game start/serve)
//  drop_cnt   out  8  saturating count of echoes dropped while busy
// BEHAVIOUR
//  Reset: all outputs 0, hold counters 0, sync flops 0, echo FSM IDLE. Async; wins over everything.
//  Input sync: rx_done and tx_busy each pass a 2-flop synchroniser (r1, r2).
//  - rx_done also feeds a third flop r3; rx_stb = r2 & ~r3.
//  - rx_data captured into byte_q when rx_stb is high.
//  Fold: bytes 0x41..0x5A get +0x20 before decode; 'w'77 's'73 'p'70 'l'6C.
//  Latency: rx_done high before edge 1 -> rx_stb high after edge 2 -> outputs change at edge 3.
//  Per player: dir register {NONE, UP, DN} and hold counter cnt.
//  - Recognised key for that player: dir <= key, cnt <= HOLD_CYCLES-1.
//  - Else if cnt != 0: cnt <= cnt-1.
//  - Else: dir <= NONE.
//  - upN = (dir == UP); downN = (dir == DN).
//  - Each output is high for exactly HOLD_CYCLES clks after its keystroke.
//  - A retrigger reloads cnt. An opposite key switches direction in the same edge.
//  - upN and downN are never both high.
//  - Unrecognised bytes leave both players untouched.
//  key_pulse: high for the single clk following edge 3 of a recognised key; 0 otherwise.
//  Echo FSM (ECHO_EN=1), byte_q printable = 0x20..0x7E after fold; echo sends the unfolded byte:
//  - IDLE: on rx_stb with printable byte -> tx_data <= byte, tx_start <= 1, go REQ.
//  - REQ: hold tx_start = 1 until synced tx_busy = 1, then tx_start <= 0, go BUSY.
//  - BUSY: wait for synced tx_busy = 0, then go IDLE.
//  - rx_stb while in REQ/BUSY: echo dropped, drop_cnt++ (saturates at 255). Paddle decode still happens.
//  - tx_data is stable from REQ entry until IDLE is re-entered.
//  - Non-printable bytes are never echoed and never counted as drops.
//  ECHO_EN=0: FSM stays IDLE, tx_start = 0, tx_data = 0, drop_cnt = 0.
//  Reset mid-hold or mid-echo: outputs drop to 0 at once. No stale pulse after release.
//  Further bytes are ignored until rx_done falls and rises again (edge detect only).
// TESTING (HOLD_CYCLES=8 in bench; rx_done/tx_busy driven as baud-like slow levels)
//  1. rx_data=0x77, rx_done pulse 16 clk -> up1=1 from edge 3 for exactly 8 clk; key_pulse one clk; tx_data=0x77 with tx_start=1.
//  2. 'S' (0x53) then 's' 4 clk later -> down1 high 8 clk after the 2nd byte (retrigger); up1 stays 0.
//  3. 'p' then 'l' 3 clk apart -> up2 high 3 clk, then down2 high 8 clk; never both high.
//  4. tx_busy stuck 1 after first echo, send 3 more bytes ('x','0','q') -> drop_cnt=3; paddles unchanged; 0x0D sent -> no drop.
//  5. 'w' then reset asserted mid-hold and mid-REQ -> up1, tx_start, key_pulse = 0 immediately; after release all idle.
//  6. rx_done held high 100 clk with 'w' -> exactly one key_pulse and one echo.

Source files
------------

// File: rtl/uart_paddle_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_paddle_decoder
// Purpose  : Converts bytes from a UART receiver into paddle commands for the
//            pong game and optionally echoes printable bytes back to the UART
//            transmitter.
//            - W/S drive player 1 up/down, P/L drive player 2 up/down
//              (case-insensitive).
//            - Each keystroke holds the matching paddle output high for
//              HOLD_CYCLES clocks. A repeat of the key reloads the hold, and
//              the opposite key switches direction immediately.
//            - Printable bytes are echoed through a start/busy handshake.
//              Echoes that arrive while a previous echo is pending are
//              dropped and counted.
// Ports    : clk        - system clock
//            reset      - asynchronous active-high reset
//            rx_data    - received byte, stable while rx_done is high
//            rx_done    - receiver byte-complete level (baud domain)
//            tx_busy    - transmitter busy level (baud domain)
//            tx_data    - byte to echo
//            tx_start   - echo request, held until tx_busy is seen
//            up1/down1  - player-1 paddle commands
//            up2/down2  - player-2 paddle commands
//            key_pulse  - one-clock pulse per recognised key
//            drop_cnt   - saturating count of dropped echoes
// Revision : 1.0 - initial release
// ============================================================================
module uart_paddle_decoder #(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter bit ECHO_EN     = 1'b1,
    parameter int CNT_W       = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       up1,
    output logic       down1,
    output logic       up2,
    output logic       down2,
    output logic       key_pulse,
    output logic [7:0] drop_cnt
);

    localparam logic [1:0]       DIR_NONE    = 2'd0;
    localparam logic [1:0]       DIR_UP      = 2'd1;
    localparam logic [1:0]       DIR_DN      = 2'd2;
    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // rx_done synchroniser plus a third stage for rising-edge detection.
    // Bit 0 = r1, bit 1 = r2, bit 2 = r3.
    // ------------------------------------------------------------------
    logic [2:0] rx_sync_d;
    logic [2:0] rx_sync_q;
    logic       w_rx_stb;

    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], rx_done};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q <= 3'b000;
        end else begin
            rx_sync_q <= rx_sync_d;
        end
    end

    // A held rx_done produces a single strobe; a new byte needs a fresh rise.
    assign w_rx_stb = rx_sync_q[1] & ~rx_sync_q[2];

    // ------------------------------------------------------------------
    // Decode. rx_data is still stable while the strobe is high, so it is
    // decoded directly; this lets the outputs move on the strobe edge.
    // ------------------------------------------------------------------
    logic [7:0] w_fold;
    logic       w_printable;
    logic [1:0] w_key_up;
    logic [1:0] w_key_dn;

    always_comb begin
        w_fold = rx_data;
        if ((rx_data >= 8'h41) && (rx_data <= 8'h5A)) begin
            w_fold = rx_data + 8'h20;
        end
    end

    assign w_printable = (w_fold >= 8'h20) && (w_fold <= 8'h7E);
    assign w_key_up[0] = w_rx_stb && (w_fold == 8'h77);   // 'w'
    assign w_key_dn[0] = w_rx_stb && (w_fold == 8'h73);   // 's'
    assign w_key_up[1] = w_rx_stb && (w_fold == 8'h70);   // 'p'
    assign w_key_dn[1] = w_rx_stb && (w_fold == 8'h6C);   // 'l'

    // ------------------------------------------------------------------
    // key_pulse
    // ------------------------------------------------------------------
    logic key_pulse_d;
    logic key_pulse_q;

    always_comb begin
        key_pulse_d = (|w_key_up) | (|w_key_dn);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_pulse_q <= 1'b0;
        end else begin
            key_pulse_q <= key_pulse_d;
        end
    end

    assign key_pulse = key_pulse_q;

    // ------------------------------------------------------------------
    // Per-player direction and hold counter. dir holds a single value, so
    // up and down can never be asserted together.
    // ------------------------------------------------------------------
    logic [1:0] w_up;
    logic [1:0] w_dn;

    for (genvar gp = 0; gp < 2; gp++) begin : g_player
        logic [1:0]       dir_d;
        logic [1:0]       dir_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cnt_q;

        always_comb begin
            dir_d = dir_q;
            cnt_d = cnt_q;
            if (w_key_up[gp]) begin
                dir_d = DIR_UP;
                cnt_d = C_HOLD_LOAD;
            end else if (w_key_dn[gp]) begin
                dir_d = DIR_DN;
                cnt_d = C_HOLD_LOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                dir_d = DIR_NONE;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dir_q <= DIR_NONE;
                cnt_q <= '0;
            end else begin
                dir_q <= dir_d;
                cnt_q <= cnt_d;
            end
        end

        assign w_up[gp] = (dir_q == DIR_UP);
        assign w_dn[gp] = (dir_q == DIR_DN);
    end

    assign up1   = w_up[0];
    assign down1 = w_dn[0];
    assign up2   = w_up[1];
    assign down2 = w_dn[1];

    // ------------------------------------------------------------------
    // Echo path
    // ------------------------------------------------------------------
    if (ECHO_EN) begin : g_echo
        localparam logic [1:0] ST_IDLE = 2'd0;
        localparam logic [1:0] ST_REQ  = 2'd1;
        localparam logic [1:0] ST_BUSY = 2'd2;

        logic [1:0] busy_sync_d;
        logic [1:0] busy_sync_q;
        logic       w_busy;
        logic [1:0] state_d;
        logic [1:0] state_q;
        logic [7:0] tx_data_d;
        logic [7:0] tx_data_q;
        logic [7:0] drop_cnt_d;
        logic [7:0] drop_cnt_q;
        logic       w_echo_req;
        logic       w_tx_start;

        always_comb begin
            busy_sync_d = {busy_sync_q[0], tx_busy};
        end

        assign w_busy     = busy_sync_q[1];
        assign w_echo_req = w_rx_stb && w_printable;

        // State register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= ST_IDLE;
                busy_sync_q <= 2'b00;
                tx_data_q   <= 8'h00;
                drop_cnt_q  <= 8'h00;
            end else begin
                state_q     <= state_d;
                busy_sync_q <= busy_sync_d;
                tx_data_q   <= tx_data_d;
                drop_cnt_q  <= drop_cnt_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (w_echo_req) state_d = ST_REQ;
                ST_REQ:  if (w_busy)     state_d = ST_BUSY;
                ST_BUSY: if (!w_busy)    state_d = ST_IDLE;
                default:                 state_d = ST_IDLE;
            endcase
        end

        // Echo datapath: tx_data only loads in IDLE, so it stays stable for
        // the whole REQ/BUSY transaction. The unfolded byte is echoed.
        always_comb begin
            tx_data_d  = tx_data_q;
            drop_cnt_d = drop_cnt_q;
            if (w_echo_req) begin
                if (state_q == ST_IDLE) begin
                    tx_data_d = rx_data;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        // Output logic
        always_comb begin
            w_tx_start = (state_q == ST_REQ);
        end

        assign tx_start = w_tx_start;
        assign tx_data  = tx_data_q;
        assign drop_cnt = drop_cnt_q;
    end else begin : g_no_echo
        assign tx_start = 1'b0;
        assign tx_data  = 8'h00;
        assign drop_cnt = 8'h00;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_paddle_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_paddle_decoder
// Purpose  : Directed self-checking bench for uart_paddle_decoder with
//            HOLD_CYCLES = 8. rx_done / tx_busy are driven as slow levels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_paddle_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       up1;
    logic       down1;
    logic       up2;
    logic       down2;
    logic       key_pulse;
    logic [7:0] drop_cnt;

    int checks;
    int failures;

    // Per-window observations, index 0..4 = up1, down1, up2, down2, key_pulse
    int hi_cnt [5];
    int first_i[5];
    int last_i [5];
    int both_hi;

    uart_paddle_decoder #(
        .HOLD_CYCLES(8),
        .ECHO_EN    (1'b1),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .up1      (up1),
        .down1    (down1),
        .up2      (up2),
        .down2    (down2),
        .key_pulse(key_pulse),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is bounded, this only guards a stall.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n clocks. Byte b0 is presented with rx_done high for cycles
    // [s0, s0+d0), byte b1 for [s1, s1+d1). Index i is sampled just after
    // clock edge i+1, so a byte rising at cycle s shows its effect at s+2.
    task automatic run_window(input int n,
                              input logic [7:0] b0, input int s0, input int d0,
                              input logic [7:0] b1, input int s1, input int d1);
        logic [4:0] v;
        for (int k = 0; k < 5; k++) begin
            hi_cnt[k]  = 0;
            first_i[k] = -1;
            last_i[k]  = -1;
        end
        both_hi = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= s0 && i < s0 + d0) begin
                rx_data = b0;
                rx_done = 1'b1;
            end else if (i >= s1 && i < s1 + d1) begin
                rx_data = b1;
                rx_done = 1'b1;
            end else begin
                rx_done = 1'b0;
            end
            tick();
            v = {key_pulse, down2, up2, down1, up1};
            for (int k = 0; k < 5; k++) begin
                if (v[k]) begin
                    hi_cnt[k]++;
                    if (first_i[k] < 0) first_i[k] = i;
                    last_i[k] = i;
                end
            end
            if ((up1 && down1) || (up2 && down2)) both_hi++;
        end
        rx_done = 1'b0;
    endtask

    // Completes an echo: busy rises (request must drop), then falls.
    task automatic handshake(input string tag, input logic [7:0] exp_data);
        tx_busy = 1'b1;
        repeat (4) tick();
        check({tag, "_start_low_busy"}, tx_start, 1'b0);
        check({tag, "_data_stable"}, tx_data, exp_data);
        tx_busy = 1'b0;
        repeat (4) tick();
        check({tag, "_start_idle"}, tx_start, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_done  = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) tick();

        // ---------------- reset state ----------------
        check("rst_up1", up1, 1'b0);
        check("rst_down1", down1, 1'b0);
        check("rst_up2", up2, 1'b0);
        check("rst_down2", down2, 1'b0);
        check("rst_key_pulse", key_pulse, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_drop_cnt", drop_cnt, 8'h00);
        reset = 1'b0;
        repeat (2) tick();

        // ---------------- 1: 'w', 16-clk rx_done ----------------
        run_window(24, 8'h77, 0, 16, 8'h00, -100, 0);
        check("t1_up1_cnt", hi_cnt[0], 8);
        check("t1_up1_first", first_i[0], 2);
        check("t1_up1_last", last_i[0], 9);
        check("t1_down1_cnt", hi_cnt[1], 0);
        check("t1_p2_cnt", hi_cnt[2] + hi_cnt[3], 0);
        check("t1_kp_cnt", hi_cnt[4], 1);
        check("t1_kp_first", first_i[4], 2);
        check("t1_tx_start", tx_start, 1'b1);
        check("t1_tx_data", tx_data, 8'h77);
        check("t1_drop", drop_cnt, 8'h00);
        handshake("t1", 8'h77);

        // ---------------- 2: 'S' then 's' 4 clk later ----------------
        // Strobes land on edges 3 and 7; the reload holds down1 to index 13.
        run_window(20, 8'h53, 0, 2, 8'h73, 4, 4);
        check("t2_down1_cnt", hi_cnt[1], 12);
        check("t2_down1_first", first_i[1], 2);
        check("t2_down1_last", last_i[1], 13);
        check("t2_up1_cnt", hi_cnt[0], 0);
        check("t2_kp_cnt", hi_cnt[4], 2);
        check("t2_tx_data", tx_data, 8'h53);
        check("t2_drop", drop_cnt, 8'h01);
        handshake("t2", 8'h53);

        // ---------------- 3: 'p' then 'l' 3 clk apart ----------------
        run_window(20, 8'h70, 0, 2, 8'h6C, 3, 4);
        check("t3_up2_cnt", hi_cnt[2], 3);
        check("t3_up2_first", first_i[2], 2);
        check("t3_down2_cnt", hi_cnt[3], 8);
        check("t3_down2_first", first_i[3], 5);
        check("t3_down2_last", last_i[3], 12);
        check("t3_both_hi", both_hi, 0);
        check("t3_p1_cnt", hi_cnt[0] + hi_cnt[1], 0);
        check("t3_tx_data", tx_data, 8'h70);
        check("t3_drop", drop_cnt, 8'h02);
        handshake("t3", 8'h70);

        // ---------------- 4: tx_busy stuck, drops ----------------
        run_window(10, 8'h61, 0, 4, 8'h00, -100, 0);
        check("t4_first_echo_start", tx_start, 1'b1);
        check("t4_first_echo_data", tx_data, 8'h61);
        tx_busy = 1'b1;
        repeat (4) tick();
        check("t4_start_low", tx_start, 1'b0);
        run_window(10, 8'h78, 0, 4, 8'h00, -100, 0);
        run_window(10, 8'h30, 0, 4, 8'h00, -100, 0);
        run_window(10, 8'h71, 0, 4, 8'h00, -100, 0);
        check("t4_no_paddle", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4], 0);
        check("t4_drop_after3", drop_cnt, 8'h05);
        run_window(10, 8'h0D, 0, 4, 8'h00, -100, 0);
        check("t4_drop_nonprint", drop_cnt, 8'h05);
        // Upper-case key while busy: decoded and counted as a drop.
        run_window(14, 8'h57, 0, 4, 8'h00, -100, 0);
        check("t4_W_up1_cnt", hi_cnt[0], 8);
        check("t4_W_drop", drop_cnt, 8'h06);
        check("t4_tx_data_held", tx_data, 8'h61);
        tx_busy = 1'b0;
        repeat (4) tick();
        check("t4_idle_start", tx_start, 1'b0);

        // ---------------- 5: reset mid-hold / mid-REQ ----------------
        run_window(3, 8'h77, 0, 4, 8'h00, -100, 0);
        check("t5_pre_kp", key_pulse, 1'b1);
        check("t5_pre_up1", up1, 1'b1);
        check("t5_pre_tx_start", tx_start, 1'b1);
        rx_done = 1'b0;
        reset   = 1'b1;
        #1;
        check("t5_async_up1", up1, 1'b0);
        check("t5_async_tx_start", tx_start, 1'b0);
        check("t5_async_kp", key_pulse, 1'b0);
        check("t5_async_drop", drop_cnt, 8'h00);
        repeat (2) tick();
        reset = 1'b0;
        run_window(12, 8'h00, -100, 0, 8'h00, -100, 0);
        check("t5_post_outputs", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4], 0);
        check("t5_post_tx_start", tx_start, 1'b0);
        check("t5_post_tx_data", tx_data, 8'h00);

        // ---------------- 6: rx_done held 100 clk ----------------
        run_window(110, 8'h77, 0, 100, 8'h00, -100, 0);
        check("t6_kp_cnt", hi_cnt[4], 1);
        check("t6_up1_cnt", hi_cnt[0], 8);
        check("t6_tx_start", tx_start, 1'b1);
        check("t6_drop", drop_cnt, 8'h00);
        handshake("t6", 8'h77);
        repeat (6) tick();
        check("t6_no_second_echo", tx_start, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
